// File: rtl/event_arbiter.sv
// Captures rising edges on async pins (3-flop sync) with a timestamp and serialises them round-robin onto one valid/ready stream.
// Edge-to-valid 3 clocks after first sample; one pending slot per channel, further edges under backpressure are dropped and counted in ovf_cnt.
module event_arbiter #(
  parameter int N_CH  = 4,
  parameter int TS_W  = 16,
  parameter int OVF_W = 8,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  sig_in,
  input  logic [N_CH-1:0]  ch_en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CH_W-1:0]  evt_ch,
  output logic [TS_W-1:0]  evt_ts,
  output logic [OVF_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);
  localparam int CNT_W = $clog2(N_CH + 1);
  localparam int SUM_W = ((OVF_W > CNT_W) ? OVF_W : CNT_W) + 1;

  typedef enum logic {IDLE, PRESENT} state_e;

  state_e                    state_q, state_d;
  logic [N_CH-1:0][2:0]      sync_q;
  logic [N_CH-1:0]           edge_p, hs_sel, req;
  logic [N_CH-1:0]           pend_q, pend_d;
  logic [N_CH-1:0][TS_W-1:0] ts_q, ts_d;
  logic [TS_W-1:0]           ts_cnt_q;
  logic [OVF_W-1:0]          ovf_q, ovf_d;
  logic [CH_W-1:0]           last_q, last_d, evt_ch_q, evt_ch_d, grant, idx;
  logic [TS_W-1:0]           evt_ts_q, evt_ts_d;
  logic [CNT_W-1:0]          n_drop;
  logic [SUM_W-1:0]          ovf_sum;
  logic                      hs, grant_vld;

  always_comb begin
    edge_p = '0;
    for (int i = 0; i < N_CH; i++) edge_p[i] = sync_q[i][1] & ~sync_q[i][2];
  end

  assign hs     = (state_q == PRESENT) & evt_ready;
  assign hs_sel = hs ? (N_CH'(1) << evt_ch_q) : '0;
  assign req    = pend_q & ch_en;

  // A handshake on the same channel frees the slot, so a coincident edge re-arms instead of dropping.
  always_comb begin
    pend_d = pend_q;
    ts_d   = ts_q;
    n_drop = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!ch_en[i]) begin
        pend_d[i] = 1'b0;
      end else if (edge_p[i]) begin
        if (!pend_q[i] || hs_sel[i]) begin
          pend_d[i] = 1'b1;
          ts_d[i]   = ts_cnt_q;
        end else begin
          n_drop = n_drop + CNT_W'(1);
        end
      end else if (hs_sel[i]) begin
        pend_d[i] = 1'b0;
      end
    end
    ovf_sum = SUM_W'(ovf_q) + SUM_W'(n_drop);
    if (ovf_clr)                       ovf_d = '0;
    else if (|ovf_sum[SUM_W-1:OVF_W])  ovf_d = '1;
    else                               ovf_d = ovf_sum[OVF_W-1:0];
  end

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = CH_W'((int'(last_q) + k) % N_CH);
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    evt_ch_d = evt_ch_q;
    evt_ts_d = evt_ts_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d  = PRESENT;
          evt_ch_d = grant;
          evt_ts_d = ts_q[grant];
        end
      end
      PRESENT: begin
        if (evt_ready) begin
          state_d = IDLE;
          last_d  = evt_ch_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      pend_q   <= '0;
      ts_q     <= '0;
      ts_cnt_q <= '0;
      ovf_q    <= '0;
      last_q   <= CH_W'(N_CH - 1);
      evt_ch_q <= '0;
      evt_ts_q <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < N_CH; i++) sync_q[i] <= {sync_q[i][1:0], sig_in[i]};
      pend_q   <= pend_d;
      ts_q     <= ts_d;
      ts_cnt_q <= ts_cnt_q + TS_W'(1);
      ovf_q    <= ovf_d;
      last_q   <= last_d;
      evt_ch_q <= evt_ch_d;
      evt_ts_q <= evt_ts_d;
    end
  end

  assign evt_valid = (state_q == PRESENT);
  assign evt_ch    = evt_ch_q;
  assign evt_ts    = evt_ts_q;
  assign ovf_cnt   = ovf_q;
endmodule

// File: tb/tb_event_arbiter.sv
// Bench for event_arbiter: directed scenarios plus random traffic against an edge-scheduled reference model.
module tb_event_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sig_in = '0;
  logic [3:0]  ch_en = 4'hF;
  logic        evt_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        evt_valid;
  logic [1:0]  evt_ch;
  logic [15:0] evt_ts;
  logic [7:0]  ovf_cnt;
  int checks = 0;
  int fails  = 0;

  event_arbiter #(.N_CH(4), .TS_W(16), .OVF_W(8)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .ch_en(ch_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch), .evt_ts(evt_ts),
    .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a rise first sampled at edge E becomes a capture at edge E+2 with timestamp E+1.
  bit          m_valid;
  logic [1:0]  m_ch;
  logic [15:0] m_ts;
  int          m_ovf, m_last, m_edge;
  bit          m_pend[4];
  logic [15:0] m_pts[4];
  bit          m_prev[4];
  int          cap_at[4][$];
  logic [15:0] cap_ts[4][$];
  int          log_ch[$], log_ts[$], log_cyc[$];
  int          g, drops, hs_ch;
  bit          hs, ev;
  logic [15:0] ev_ts;
  logic [1:0]  ix;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_ch = 0; m_ts = 0; m_ovf = 0; m_last = 3; m_edge = 0;
      for (int c = 0; c < 4; c++) begin
        m_pend[c] = 0; m_pts[c] = 0; m_prev[c] = 0;
        cap_at[c].delete(); cap_ts[c].delete();
      end
    end else begin
      m_edge++;
      if (evt_valid && evt_ready) begin
        log_ch.push_back(int'(evt_ch)); log_ts.push_back(int'(evt_ts)); log_cyc.push_back(m_edge);
      end
      hs = m_valid && evt_ready; hs_ch = int'(m_ch); drops = 0; g = -1;
      if (!m_valid)
        for (int k = 1; k <= 4; k++) begin
          ix = 2'((m_last + k) % 4);
          if (g < 0 && m_pend[ix] && ch_en[ix]) g = int'(ix);
        end
      if (hs) begin
        m_valid = 0; m_last = hs_ch;
      end else if (g >= 0) begin
        m_valid = 1; m_ch = 2'(g); m_ts = m_pts[g];
      end
      for (int c = 0; c < 4; c++) begin
        ev = 0;
        if (cap_at[c].size() > 0 && cap_at[c][0] == m_edge) begin
          ev = 1; ev_ts = cap_ts[c].pop_front(); void'(cap_at[c].pop_front());
        end
        if (!ch_en[c]) m_pend[c] = 0;
        else if (ev) begin
          if (!m_pend[c] || (hs && hs_ch == c)) begin m_pend[c] = 1; m_pts[c] = ev_ts; end
          else drops++;
        end else if (hs && hs_ch == c) m_pend[c] = 0;
        if (sig_in[c] && !m_prev[c]) begin
          cap_at[c].push_back(m_edge + 2); cap_ts[c].push_back(16'(m_edge + 1));
        end
        m_prev[c] = sig_in[c];
      end
      m_ovf = ovf_clr ? 0 : ((m_ovf + drops > 255) ? 255 : m_ovf + drops);
    end
  end

  function automatic logic [26:0] dut_obs();
    return {evt_valid, evt_ch, evt_ts, ovf_cnt};
  endfunction
  function automatic logic [26:0] mdl_obs();
    return {m_valid, m_ch, m_ts, 8'(m_ovf)};
  endfunction

  task automatic clear_log();
    log_ch.delete(); log_ts.delete(); log_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; #1 rst = 1'b1;
    sig_in = '0; ch_en = 4'hF; evt_ready = 0; ovf_clr = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_obs() !== 27'd0) begin fails++; $display("FAIL reset_state: got %h want 0", dut_obs()); end
    rst = 1'b0;
  endtask

  task automatic test_single_edge();
    clear_log();
    evt_ready = 1;
    repeat (4) @(negedge clk);
    sig_in[2] = 1'b1;
    for (int k = 5; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (evt_valid !== (k == 8)) begin fails++; $display("FAIL single_valid_E%0d: got %b want %b", k, evt_valid, (k == 8)); end
      checks++;
      if (dut_obs() !== mdl_obs()) begin fails++; $display("FAIL single_model: got %h want %h", dut_obs(), mdl_obs()); end
    end
    sig_in[2] = 1'b0;
    checks++;
    if (log_ch.size() != 1) begin fails++; $display("FAIL single_count: got %0d events want 1", log_ch.size()); end
    else begin
      checks++;
      if (log_ch[0] != 2 || log_ts[0] != 6 || log_cyc[0] != 9) begin
        fails++; $display("FAIL single_event: got ch=%0d ts=%0d edge=%0d want ch=2 ts=6 edge=9", log_ch[0], log_ts[0], log_cyc[0]);
      end
    end
  endtask

  task automatic test_round_robin();
    int t0, p;
    evt_ready = 1; ch_en = 4'hF;
    for (int r = 0; r < 2; r++) begin
      p = (r == 0) ? 3 : 1;
      sig_in[p] = 1'b1; @(negedge clk); sig_in[p] = 1'b0;
      repeat (8) @(negedge clk);
      clear_log();
      t0 = m_edge;
      sig_in = 4'hF;
      for (int k = 0; k < 14; k++) begin
        @(negedge clk);
        if (k == 2) sig_in = '0;
        checks++;
        if (dut_obs() !== mdl_obs()) begin fails++; $display("FAIL rr_model: got %h want %h", dut_obs(), mdl_obs()); end
      end
      checks++;
      if (log_ch.size() != 4) begin fails++; $display("FAIL rr_count: got %0d events want 4", log_ch.size()); end
      else for (int j = 0; j < 4; j++) begin
        checks++;
        if (log_ch[j] != (p + 1 + j) % 4 || log_ts[j] != int'(16'(t0 + 2)) || log_cyc[j] != t0 + 5 + 2 * j) begin
          fails++;
          $display("FAIL rr_grant%0d: got ch=%0d ts=%0d edge=%0d want ch=%0d ts=%0d edge=%0d",
                   j, log_ch[j], log_ts[j], log_cyc[j], (p + 1 + j) % 4, int'(16'(t0 + 2)), t0 + 5 + 2 * j);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int t0;
    evt_ready = 0; ovf_clr = 1; @(negedge clk); ovf_clr = 0;
    clear_log();
    t0 = m_edge;
    for (int n = 0; n < 3; n++) begin
      sig_in[0] = 1'b1; @(negedge clk); sig_in[0] = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (dut_obs() !== mdl_obs()) begin fails++; $display("FAIL bp_model: got %h want %h", dut_obs(), mdl_obs()); end
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({evt_valid, evt_ch, evt_ts, ovf_cnt} !== {1'b1, 2'd0, 16'(t0 + 2), 8'd2}) begin
      fails++; $display("FAIL bp_hold: got v=%b ch=%0d ts=%0d ovf=%0d want v=1 ch=0 ts=%0d ovf=2", evt_valid, evt_ch, evt_ts, ovf_cnt, t0 + 2);
    end
    evt_ready = 1;
    repeat (6) @(negedge clk);
    checks++;
    if (log_ch.size() != 1 || evt_valid !== 1'b0 || ovf_cnt !== 8'd2) begin
      fails++; $display("FAIL bp_drain: got events=%0d v=%b ovf=%0d want events=1 v=0 ovf=2", log_ch.size(), evt_valid, ovf_cnt);
    end
    ovf_clr = 1; @(negedge clk); ovf_clr = 0;
    checks++;
    if (ovf_cnt !== 8'd0) begin fails++; $display("FAIL bp_clr: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_saturation();
    evt_ready = 0;
    sig_in[1] = 1'b1; @(negedge clk); sig_in[1] = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (evt_valid !== 1'b1 || evt_ch !== 2'd1) begin fails++; $display("FAIL sat_block: got v=%b ch=%0d want v=1 ch=1", evt_valid, evt_ch); end
    for (int n = 0; n < 300; n++) begin
      sig_in[1] = 1'b1; @(negedge clk); sig_in[1] = 1'b0; @(negedge clk);
      checks++;
      if (dut_obs() !== mdl_obs()) begin fails++; $display("FAIL sat_model: got %h want %h", dut_obs(), mdl_obs()); end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (ovf_cnt !== 8'd255) begin fails++; $display("FAIL sat_value: got %0d want 255", ovf_cnt); end
    evt_ready = 1; repeat (4) @(negedge clk);
    ovf_clr = 1; @(negedge clk); ovf_clr = 0;
  endtask

  task automatic test_enable_mask();
    clear_log();
    evt_ready = 1; ch_en = 4'b1101;
    sig_in[1] = 1'b1; @(negedge clk); sig_in[1] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (evt_valid !== 1'b0) begin fails++; $display("FAIL mask_ch1: got valid %b want 0", evt_valid); end
    end
    evt_ready = 0;
    sig_in[0] = 1'b1; @(negedge clk); sig_in[0] = 1'b0;
    repeat (2) @(negedge clk);
    sig_in[3] = 1'b1; @(negedge clk); sig_in[3] = 1'b0;
    repeat (4) @(negedge clk);
    ch_en = 4'b0101; @(negedge clk);
    evt_ready = 1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 8) ch_en = 4'hF;
      checks++;
      if (dut_obs() !== mdl_obs()) begin fails++; $display("FAIL mask_model: got %h want %h", dut_obs(), mdl_obs()); end
    end
    checks++;
    if (log_ch.size() != 1) begin fails++; $display("FAIL mask_events: got %0d events want 1", log_ch.size()); end
    else begin
      checks++;
      if (log_ch[0] != 0) begin fails++; $display("FAIL mask_chan: got ch=%0d want 0", log_ch[0]); end
    end
  endtask

  task automatic test_rearm();
    int t0;
    clear_log();
    evt_ready = 0;
    sig_in[0] = 1'b1; @(negedge clk); sig_in[0] = 1'b0;
    repeat (5) @(negedge clk);
    t0 = m_edge;
    sig_in[0] = 1'b1;
    @(negedge clk); sig_in[0] = 1'b0;
    @(negedge clk); evt_ready = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (dut_obs() !== mdl_obs()) begin fails++; $display("FAIL rearm_model: got %h want %h", dut_obs(), mdl_obs()); end
    end
    checks++;
    if (log_ch.size() != 2) begin fails++; $display("FAIL rearm_count: got %0d events want 2", log_ch.size()); end
    else begin
      checks++;
      if (log_ch[1] != 0 || log_ts[1] != int'(16'(t0 + 2)) || log_cyc[0] != t0 + 3 || log_cyc[1] != t0 + 5) begin
        fails++; $display("FAIL rearm_event: got ch=%0d ts=%0d edges=%0d,%0d want ch=0 ts=%0d edges=%0d,%0d",
                          log_ch[1], log_ts[1], log_cyc[0], log_cyc[1], t0 + 2, t0 + 3, t0 + 5);
      end
    end
    checks++;
    if (ovf_cnt !== 8'd0) begin fails++; $display("FAIL rearm_ovf: got %0d want 0", ovf_cnt); end
  endtask

  task automatic test_reset_midflight();
    evt_ready = 0;
    sig_in[2] = 1'b1; @(negedge clk); sig_in[2] = 1'b0;
    repeat (5) @(negedge clk);
    sig_in[1] = 1'b1; @(negedge clk); sig_in[1] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (evt_valid !== 1'b1) begin fails++; $display("FAIL rst_pre: got valid %b want 1", evt_valid); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_obs() !== 27'd0) begin fails++; $display("FAIL rst_async: got %h want 0", dut_obs()); end
    @(negedge clk); rst = 1'b0;
    clear_log();
    evt_ready = 1;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (dut_obs() !== 27'd0) begin fails++; $display("FAIL rst_stale: got %h want 0", dut_obs()); end
    end
    checks++;
    if (log_ch.size() != 0) begin fails++; $display("FAIL rst_events: got %0d events want 0", log_ch.size()); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      checks++;
      if (dut_obs() !== mdl_obs()) begin fails++; $display("FAIL rand_model cyc %0d: got %h want %h", n, dut_obs(), mdl_obs()); end
      if ($urandom_range(0, 3) == 0) sig_in = 4'($urandom);
      evt_ready = ($urandom_range(0, 2) != 0);
      ch_en     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      ovf_clr   = ($urandom_range(0, 40) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_round_robin();
    test_backpressure();
    test_saturation();
    test_enable_mask();
    test_rearm();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
